load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the CPU MEM stage, between the CPU data port and the synchronous data SRAM.
- Converts one CPU load/store request into a fixed-latency SRAM access:
  - store byte-lane enables and write-data replication;
  - load lane extraction with sign/zero extension.
- Holds the pipeline through a stall output until the access completes.

Parameters:
- ADDR_W, 14: width of the SRAM word address; dm_addr = req_addr[ADDR_W+1:2].
- MEM_LAT, 1: SRAM read/write latency in cycles, legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  MEM stage holds a load or store
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I size/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data (rs2, already forwarded)
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
- rdata_out  output  32  extended load data
- rdata_valid  output  1  one-cycle pulse when rdata_out holds a new load result
- misalign_err  output  1  one-cycle pulse on misaligned access (only when MISALIGN_TRAP_EN is defined)
- dm_cs  output  1  SRAM chip select
- dm_web  output  4  active-low byte write enables; 4'hF = no write
- dm_addr  output  ADDR_W  SRAM word address
- dm_data_in  output  32  SRAM write data
- dm_data_out  input  32  SRAM read data, valid MEM_LAT cycles after address

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst; it is the only reset.
- Reset values:
  - state IDLE, counter 0;
  - stall 0, rdata_out 0, rdata_valid 0, misalign_err 0;
  - dm_cs 0, dm_web 4'hF, dm_addr 0, dm_data_in 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: stall = req_valid (combinational). If req_valid=1, latch we, funct3, addr and wdata, load counter with MEM_LAT-1, and go to ACCESS.
  - ACCESS:
    - stall=1, dm_cs=1, dm_addr driven from the latched address.
    - Counter decrements each cycle.
    - On the cycle counter==0:
      - a store drives dm_web to the lane mask (asserted for exactly one cycle);
      - a load samples dm_data_out at the clock edge.
    - Then go to DONE.
  - DONE: stall=0, dm_cs=0, dm_web=4'hF. A load asserts rdata_valid=1 with extended data on rdata_out. Next state is IDLE unconditionally. req_valid is ignored in DONE, because the CPU advances on this edge.
- Stall length per access = MEM_LAT+1 cycles. Occupancy = MEM_LAT+2 cycles. Back-to-back requests are spaced by MEM_LAT+2 cycles minimum.
- Store lane mask (active-low on dm_web):
  - SB: lane a[1:0] cleared.
  - SH: lanes {a[1],0} and {a[1],1} cleared.
  - SW: 4'h0.
- Store data: SB replicates wdata[7:0] x4; SH replicates wdata[15:0] x2; SW passes wdata unchanged.
- Load extraction: byte lane a[1:0] or half lane a[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- funct3 011, 110 and 111 are treated as word accesses.
- rdata_out holds its last value until the next load completes. Stores leave rdata_out unchanged and never pulse rdata_valid.
- Reset mid-access: returns to IDLE at the same edge, dm_web=4'hF from the next cycle, and no partial write is issued after reset.
- MEM_LAT=1: ACCESS lasts one cycle, counter loaded with 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, a halfword with addr[0]=1 or a word with addr[1:0]!=0:
  - skips ACCESS and goes straight to DONE;
  - pulses misalign_err in DONE with dm_cs=0 and no write;
  - a load leaves rdata_out unchanged and keeps rdata_valid=0.
- Undefined: misalign_err is tied 0. Low address bits are forced to natural alignment (H clears a[0], W clears a[1:0]) and the access proceeds normally.

Test Plan:
- Reset: hold rst=1 with req_valid=1 -> stall=0, dm_cs=0, dm_web=4'hF, rdata_out=0.
- SW addr 0x0000_0010, data 0xDEADBEEF, MEM_LAT=1 -> dm_addr=4, dm_web=4'h0 for one cycle, dm_data_in=0xDEADBEEF, stall high 2 cycles.
- SB addr 0x13, data 0x000000A5 -> dm_web=4'b0111, dm_data_in=0xA5A5A5A5. SH addr 0x12, data 0x1234 -> dm_web=4'b0011.
- Memory word 0x80FF7F01 at word 5: LB 0x17 -> 0xFFFFFF80; LBU 0x17 -> 0x00000080; LH 0x14 -> 0x00007F01; LHU 0x16 -> 0x000080FF; each with a single rdata_valid pulse.
- MEM_LAT=3, two consecutive LW -> stall high 4 cycles each; second request accepted exactly 5 cycles after the first.
- rst asserted during ACCESS of an SW (MEM_LAT=3, counter=1) -> no dm_web assertion afterwards, memory unchanged. LH 0x11 with macro defined -> misalign_err pulse, dm_cs stays 0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store to fixed-latency sync SRAM bridge; define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
module load_store_unit #(
  parameter int ADDR_W = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic              dm_cs,
  output logic [3:0]        dm_web,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_data_in,
  input  logic [31:0]       dm_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q;
  logic req_byte, req_half, req_mis, q_byte, q_half, last;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [3:0] mask;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign req_byte = req_funct3[1:0] == 2'b00;
  assign req_half = req_funct3[1:0] == 2'b01;
  assign q_byte = f3_q[1:0] == 2'b00;
  assign q_half = f3_q[1:0] == 2'b01;
  assign last = state == ACCESS && cnt == 4'd0;
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = (req_half & req_addr[0]) | (~req_byte & ~req_half & (|req_addr[1:0]));
`else
  assign req_mis = 1'b0;
`endif
  assign dm_addr = addr_q[ADDR_W+1:2];
  assign dm_data_in = wdata_q;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  // next state: misaligned trapped requests bypass the SRAM access
  always_comb
    state_nxt = state == IDLE ? (req_valid ? (req_mis ? DONE : ACCESS) : IDLE) :
                state == ACCESS ? (cnt == 4'd0 ? DONE : ACCESS) : IDLE;
  // request capture (naturally aligned, store data pre-replicated), latency counter and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= '0;
      wdata_q <= 32'd0;
      rdata_out <= 32'd0;
      rdata_valid <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      rdata_valid <= last && !we_q;
      misalign_err <= state == IDLE && req_valid && req_mis;
      if (state == ACCESS) cnt <= cnt - 4'd1;
      if (last && !we_q) rdata_out <= ext;
      if (state == IDLE && req_valid) begin
        cnt <= 4'(MEM_LAT - 1);
        we_q <= req_we;
        f3_q <= req_funct3;
        addr_q <= {req_addr[ADDR_W+1:2], req_byte ? req_addr[1:0] : req_half ? {req_addr[1], 1'b0} : 2'b00};
        wdata_q <= req_byte ? {4{req_wdata[7:0]}} : req_half ? {2{req_wdata[15:0]}} : req_wdata;
      end
    end
  end
  // load lane extraction/extension and store lane mask
  always_comb begin
    lane_b = dm_data_out[{addr_q[1:0], 3'b000} +: 8];
    lane_h = dm_data_out[{addr_q[1], 4'b0000} +: 16];
    ext = q_byte ? {{24{lane_b[7] & ~f3_q[2]}}, lane_b} :
          q_half ? {{16{lane_h[15] & ~f3_q[2]}}, lane_h} : dm_data_out;
    mask = q_byte ? ~(4'b0001 << addr_q[1:0]) : q_half ? (addr_q[1] ? 4'b0011 : 4'b1100) : 4'b0000;
  end
  // outputs: write strobe only on the final access cycle and never while reset is asserted
  always_comb begin
    stall = state == ACCESS || (state == IDLE && req_valid && !rst);
    dm_cs = state == ACCESS;
    dm_web = (last && we_q && !rst) ? mask : 4'hF;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit at MEM_LAT=1 (instance a) and MEM_LAT=3 (instance b)
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_a, rst_b, req_valid, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic stall_a, rv_a, mis_a, cs_a, stall_b, rv_b, mis_b, cs_b;
  logic [31:0] rdata_a, din_a, dout_a, rdata_b, din_b, dout_b;
  logic [3:0] web_a, web_b;
  logic [13:0] addr_a, addr_b;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  int checks = 0;
  int failures = 0;
  logic [9:0] exp_stall, exp_rv;
  always #5 clk = ~clk;
  load_store_unit #(.ADDR_W(14), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_a), .rdata_out(rdata_a),
    .rdata_valid(rv_a), .misalign_err(mis_a), .dm_cs(cs_a), .dm_web(web_a), .dm_addr(addr_a),
    .dm_data_in(din_a), .dm_data_out(dout_a)
  );
  load_store_unit #(.ADDR_W(14), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_b), .rdata_out(rdata_b),
    .rdata_valid(rv_b), .misalign_err(mis_b), .dm_cs(cs_b), .dm_web(web_b), .dm_addr(addr_b),
    .dm_data_in(din_b), .dm_data_out(dout_b)
  );
  assign dout_a = mem_a[addr_a[3:0]];
  assign dout_b = mem_b[addr_b[3:0]];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cs_a && !web_a[i]) mem_a[addr_a[3:0]][8*i +: 8] <= din_a[8*i +: 8];
      if (cs_b && !web_b[i]) mem_b[addr_b[3:0]][8*i +: 8] <= din_b[8*i +: 8];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
  endtask
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] web, input logic [31:0] din);
    issue(1'b1, f3, a, d);
    #1 chk({tag, "_stall_req"}, 32'(stall_a), 32'd1);
    tick;
    req_valid = 1'b0;
    #1 chk({tag, "_cs"}, 32'(cs_a), 32'd1);
    chk({tag, "_stall_acc"}, 32'(stall_a), 32'd1);
    chk({tag, "_web"}, 32'(web_a), 32'(web));
    chk({tag, "_din"}, din_a, din);
    chk({tag, "_addr"}, 32'(addr_a), {18'd0, a[15:2]});
    tick;
    #1 chk({tag, "_web_done"}, 32'(web_a), 32'hF);
    chk({tag, "_stall_done"}, 32'(stall_a), 32'd0);
    chk({tag, "_rv_done"}, 32'(rv_a), 32'd0);
    tick;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'd0);
    #1 chk({tag, "_stall_req"}, 32'(stall_a), 32'd1);
    tick;
    req_valid = 1'b0;
    #1 chk({tag, "_rv_acc"}, 32'(rv_a), 32'd0);
    chk({tag, "_web_acc"}, 32'(web_a), 32'hF);
    tick;
    #1 chk({tag, "_rv"}, 32'(rv_a), 32'd1);
    chk({tag, "_data"}, rdata_a, exp);
    chk({tag, "_mis"}, 32'(mis_a), 32'd0);
    tick;
    #1 chk({tag, "_rv_pulse"}, 32'(rv_a), 32'd0);
    chk({tag, "_hold"}, rdata_a, exp);
  endtask
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    issue(1'b0, 3'b010, 32'h0, 32'h0);
    tick;
    tick;
    #1 chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_cs", 32'(cs_a), 32'd0);
    chk("rst_web", 32'(web_a), 32'hF);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_rv", 32'(rv_a), 32'd0);
    chk("rst_mis", 32'(mis_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_din", din_a, 32'd0);
    chk("rst_stall_b", 32'(stall_b), 32'd0);
    tick;
    rst_a = 1'b0;
    req_valid = 1'b0;
    tick;
    do_store("sw", 3'b010, 32'h10, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF);
    chk("sw_mem", mem_a[4], 32'hDEADBEEF);
    do_store("sw5", 3'b010, 32'h14, 32'h80FF7F01, 4'h0, 32'h80FF7F01);
    do_load("lb", 3'b000, 32'h17, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h17, 32'h00000080);
    do_load("lh", 3'b001, 32'h14, 32'h00007F01);
    do_load("lhu", 3'b101, 32'h16, 32'h000080FF);
    do_load("lw011", 3'b011, 32'h14, 32'h80FF7F01);
    do_store("sb", 3'b000, 32'h13, 32'h000000A5, 4'b0111, 32'hA5A5A5A5);
    chk("sb_keeps_rdata", rdata_a, 32'h80FF7F01);
    do_store("sh", 3'b001, 32'h12, 32'h00001234, 4'b0011, 32'h12341234);
    chk("sh_mem", mem_a[4], 32'h1234BEEF);
    do_load("lw", 3'b010, 32'h10, 32'h1234BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b001, 32'h11, 32'h0);
    #1 chk("mis_stall_req", 32'(stall_a), 32'd1);
    tick;
    req_valid = 1'b0;
    #1 chk("mis_err", 32'(mis_a), 32'd1);
    chk("mis_cs", 32'(cs_a), 32'd0);
    chk("mis_web", 32'(web_a), 32'hF);
    chk("mis_rv", 32'(rv_a), 32'd0);
    chk("mis_rdata", rdata_a, 32'h1234BEEF);
    chk("mis_stall", 32'(stall_a), 32'd0);
    tick;
    #1 chk("mis_pulse", 32'(mis_a), 32'd0);
`else
    do_load("lh_unaligned", 3'b001, 32'h11, 32'hFFFFBEEF);
`endif
    rst_a = 1'b1;
    rst_b = 1'b0;
    tick;
    issue(1'b1, 3'b010, 32'h18, 32'h11111111);
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    chk("b_sw_mem", mem_b[6], 32'h11111111);
    exp_stall = 10'b0111101111;
    exp_rv = 10'b1000010000;
    issue(1'b0, 3'b010, 32'h18, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("b_lw_stall_%0d", i), 32'(stall_b), 32'(exp_stall[i]));
      chk($sformatf("b_lw_rv_%0d", i), 32'(rv_b), 32'(exp_rv[i]));
      tick;
    end
    req_valid = 1'b0;
    chk("b_lw_data", rdata_b, 32'h11111111);
    tick;
    issue(1'b1, 3'b010, 32'h18, 32'hCAFEF00D);
    tick;
    req_valid = 1'b0;
    #1 chk("b_rst_cs", 32'(cs_b), 32'd1);
    chk("b_rst_web_c2", 32'(web_b), 32'hF);
    tick;
    rst_b = 1'b1;
    #1 chk("b_rst_web_c1", 32'(web_b), 32'hF);
    tick;
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("b_post_rst_web_%0d", i), 32'(web_b), 32'hF);
      chk($sformatf("b_post_rst_cs_%0d", i), 32'(cs_b), 32'd0);
      chk($sformatf("b_post_rst_stall_%0d", i), 32'(stall_b), 32'd0);
      tick;
    end
    chk("b_rst_mem", mem_b[6], 32'h11111111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
